count_seq_monitor: RTL and testbench

- Downstream observer stage for the 4-bit loadable up-counter; consumes its `count` output every clock.
- Flags wrap-around (15->0), match against a programmable value, and out-of-sequence jumps caused by parallel loads.
- Keeps saturating event tallies and a "locked" status for the system controller and for bench self-checking.

---
 rtl/count_seq_monitor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_count_seq_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
// Observer stage for a loadable up-counter. Every clock it compares the
// counter value against the value seen on the previous edge and reports
// wrap-around (all-ones -> zero), matches against a programmable value, and
// out-of-sequence jumps such as those caused by parallel loads. Saturating
// tallies of wraps and jumps plus a "locked" flag summarise sequence health.
//
// Control flow is a three-state FSM:
//   IDLE  : monitor disabled; prev holds, pulses and lock are cleared.
//   SYNC  : first enabled edge after IDLE captures a fresh reference value
//           into prev without checking it, so stale history never produces
//           a false jump.
//   TRACK : every edge classifies the step prev -> count_in.
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.

module count_seq_monitor #(
    parameter int WIDTH  = 4,
    parameter int EVT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] match_val,
    output logic             wrap_pulse,
    output logic             match_pulse,
    output logic             jump_pulse,
    output logic             locked,
    output logic [EVT_W-1:0] wrap_cnt,
    output logic [EVT_W-1:0] jump_cnt
);

    // step_run must be able to hold the value LOCK_N itself.
    localparam int RUN_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Event tally increment that sticks at all-ones instead of rolling over.
    function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] value);
        logic [EVT_W-1:0] result;
        if (value == {EVT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + EVT_W'(1'b1);
        end
        return result;
    endfunction

    // Legal-step run increment that stops at the lock threshold.
    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] value);
        logic [RUN_W-1:0] result;
        if (value >= RUN_W'(LOCK_N)) begin
            result = RUN_W'(LOCK_N);
        end else begin
            result = value + RUN_W'(1'b1);
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] prev_r;
    logic [RUN_W-1:0] step_run_r;
    logic             wrap_pulse_r;
    logic             match_pulse_r;
    logic             jump_pulse_r;
    logic             locked_r;
    logic [EVT_W-1:0] wrap_cnt_r;
    logic [EVT_W-1:0] jump_cnt_r;

    // Next-value signals produced by the output/datapath process
    logic [WIDTH-1:0] prev_nxt_s;
    logic [RUN_W-1:0] step_run_nxt_s;
    logic             wrap_pulse_nxt_s;
    logic             match_pulse_nxt_s;
    logic             jump_pulse_nxt_s;
    logic             locked_nxt_s;
    logic [EVT_W-1:0] wrap_cnt_nxt_s;
    logic [EVT_W-1:0] jump_cnt_nxt_s;

    // Step classification and event detection
    logic [WIDTH-1:0] prev_plus_one_s;
    logic             is_inc_s;
    logic             is_hold_s;
    logic             is_jump_s;
    logic             is_wrap_s;
    logic             is_match_s;
    logic             eval_s;
    logic             wrap_evt_s;
    logic             match_evt_s;
    logic             jump_evt_s;

    // ------------------------------------------------------------------
    // Step classification
    // ------------------------------------------------------------------

    // Classify the step prev -> count_in and qualify events with TRACK+en.
    always_comb begin
        prev_plus_one_s = prev_r + WIDTH'(1'b1);
        is_inc_s        = (count_in == prev_plus_one_s);
        is_hold_s       = (count_in == prev_r);
        is_jump_s       = (!is_inc_s) && (!is_hold_s);
        // A wrap is a special case of a legal increment.
        is_wrap_s       = (prev_r == {WIDTH{1'b1}}) && (count_in == {WIDTH{1'b0}});
        // Edge-qualified so a held matching value only reports once.
        is_match_s      = (count_in == match_val) && (!is_hold_s);

        if ((state_r == ST_TRACK) && en) begin
            eval_s = 1'b1;
        end else begin
            eval_s = 1'b0;
        end

        wrap_evt_s  = eval_s && is_wrap_s;
        match_evt_s = eval_s && is_match_s;
        jump_evt_s  = eval_s && is_jump_s;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------

    // FSM state register; reset forces IDLE ahead of everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: en advances IDLE -> SYNC -> TRACK, en low returns to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (en) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (en) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: clr beats disable, disable beats events.
    always_comb begin
        // Pulses and lock default low; they are only raised by a TRACK evaluation.
        wrap_pulse_nxt_s  = 1'b0;
        match_pulse_nxt_s = 1'b0;
        jump_pulse_nxt_s  = 1'b0;
        locked_nxt_s      = 1'b0;
        step_run_nxt_s    = step_run_r;
        wrap_cnt_nxt_s    = wrap_cnt_r;
        jump_cnt_nxt_s    = jump_cnt_r;

        // prev tracks the counter in SYNC and TRACK regardless of en or clr.
        if (state_r != ST_IDLE) begin
            prev_nxt_s = count_in;
        end else begin
            prev_nxt_s = prev_r;
        end

        if (clr) begin
            // Clear wins over any event detected on the same edge.
            step_run_nxt_s = {RUN_W{1'b0}};
            wrap_cnt_nxt_s = {EVT_W{1'b0}};
            jump_cnt_nxt_s = {EVT_W{1'b0}};
        end else if (!en) begin
            // Heading to IDLE: the run is restarted so locked always equals
            // (step_run == LOCK_N) after re-enable; tallies are kept.
            step_run_nxt_s = {RUN_W{1'b0}};
        end else if (eval_s) begin
            wrap_pulse_nxt_s  = wrap_evt_s;
            match_pulse_nxt_s = match_evt_s;
            jump_pulse_nxt_s  = jump_evt_s;

            if (jump_evt_s) begin
                step_run_nxt_s = {RUN_W{1'b0}};
            end else if (is_inc_s) begin
                step_run_nxt_s = sat_inc_run(step_run_r);
            end else begin
                // Hold is legal but does not extend the run.
                step_run_nxt_s = step_run_r;
            end

            if (wrap_evt_s) begin
                wrap_cnt_nxt_s = sat_inc_evt(wrap_cnt_r);
            end else begin
                wrap_cnt_nxt_s = wrap_cnt_r;
            end

            if (jump_evt_s) begin
                jump_cnt_nxt_s = sat_inc_evt(jump_cnt_r);
            end else begin
                jump_cnt_nxt_s = jump_cnt_r;
            end

            locked_nxt_s = (step_run_nxt_s == RUN_W'(LOCK_N));
        end else begin
            // Enabled in IDLE or SYNC: nothing is checked yet, run holds.
            step_run_nxt_s = step_run_r;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Register prev, the legal-step run, pulses, lock and tallies.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r        <= {WIDTH{1'b0}};
            step_run_r    <= {RUN_W{1'b0}};
            wrap_pulse_r  <= 1'b0;
            match_pulse_r <= 1'b0;
            jump_pulse_r  <= 1'b0;
            locked_r      <= 1'b0;
            wrap_cnt_r    <= {EVT_W{1'b0}};
            jump_cnt_r    <= {EVT_W{1'b0}};
        end else begin
            prev_r        <= prev_nxt_s;
            step_run_r    <= step_run_nxt_s;
            wrap_pulse_r  <= wrap_pulse_nxt_s;
            match_pulse_r <= match_pulse_nxt_s;
            jump_pulse_r  <= jump_pulse_nxt_s;
            locked_r      <= locked_nxt_s;
            wrap_cnt_r    <= wrap_cnt_nxt_s;
            jump_cnt_r    <= jump_cnt_nxt_s;
        end
    end

    assign wrap_pulse  = wrap_pulse_r;
    assign match_pulse = match_pulse_r;
    assign jump_pulse  = jump_pulse_r;
    assign locked      = locked_r;
    assign wrap_cnt    = wrap_cnt_r;
    assign jump_cnt    = jump_cnt_r;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed self-checking bench for count_seq_monitor.
// Inputs are applied between edges, tick() advances one rising edge and
// settles #1, then outputs reflect the edge that sampled those inputs.

module tb_count_seq_monitor;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic [3:0] count_in;
    logic [3:0] match_val;
    logic       wrap_pulse;
    logic       match_pulse;
    logic       jump_pulse;
    logic       locked;
    logic [7:0] wrap_cnt;
    logic [7:0] jump_cnt;

    int tests_run;
    int tests_failed;

    count_seq_monitor #(
        .WIDTH (4),
        .EVT_W (8),
        .LOCK_N(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .count_in   (count_in),
        .match_val  (match_val),
        .wrap_pulse (wrap_pulse),
        .match_pulse(match_pulse),
        .jump_pulse (jump_pulse),
        .locked     (locked),
        .wrap_cnt   (wrap_cnt),
        .jump_cnt   (jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_all(input string tag, input int w, input int m, input int j,
                           input int l, input int wc, input int jc);
        chk({tag, ".wrap_pulse"},  int'(wrap_pulse),  w);
        chk({tag, ".match_pulse"}, int'(match_pulse), m);
        chk({tag, ".jump_pulse"},  int'(jump_pulse),  j);
        chk({tag, ".locked"},      int'(locked),      l);
        chk({tag, ".wrap_cnt"},    int'(wrap_cnt),    wc);
        chk({tag, ".jump_cnt"},    int'(jump_cnt),    jc);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        en           = 1'b0;
        clr          = 1'b0;
        count_in     = 4'd7;
        match_val    = 4'd0;

        // 1. Reset state, then lock after four legal steps
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        reset     = 1'b0;
        en        = 1'b1;
        count_in  = 4'd0;
        match_val = 4'd15;
        tick();                               // IDLE -> SYNC
        chk_all("t1_idle2sync", 0, 0, 0, 0, 0, 0);
        tick();                               // SYNC captures prev=0
        chk_all("t1_sync", 0, 0, 0, 0, 0, 0);
        for (int v = 1; v <= 4; v++) begin
            count_in = 4'(v);
            tick();
            chk_all($sformatf("t1_step%0d", v), 0, 0, 0, (v == 4) ? 1 : 0, 0, 0);
        end

        // 2. Free-run through 15 -> 0 with match_val=5
        match_val = 4'd5;
        for (int v = 5; v <= 16; v++) begin
            count_in = 4'(v);
            tick();
            chk_all($sformatf("t2_cnt%0d", v), (v == 16) ? 1 : 0, (v == 5) ? 1 : 0,
                    0, 1, (v == 16) ? 1 : 0, 0);
        end

        // 3. Parallel load 6 -> 13, relock, wrap coincident with match of 0
        for (int v = 1; v <= 6; v++) begin
            count_in = 4'(v);
            tick();
        end
        chk("t3_pre_locked", int'(locked), 1);
        match_val = 4'd0;
        count_in  = 4'd13;
        tick();
        chk_all("t3_load13", 0, 0, 1, 0, 1, 1);
        count_in = 4'd14;
        tick();
        chk_all("t3_14", 0, 0, 0, 0, 1, 1);
        count_in = 4'd15;
        tick();
        chk_all("t3_15", 0, 0, 0, 0, 1, 1);
        count_in = 4'd0;
        tick();
        chk_all("t3_wrap_match", 1, 1, 0, 0, 2, 1);
        count_in = 4'd1;
        tick();
        chk_all("t3_relock", 0, 0, 0, 1, 2, 1);

        // 4. Held match pulses once; holds do not advance the run
        match_val = 4'd5;
        count_in  = 4'd3;
        tick();
        chk_all("t4_jump", 0, 0, 1, 0, 2, 2);
        count_in = 4'd4;
        tick();
        chk_all("t4_4", 0, 0, 0, 0, 2, 2);
        count_in = 4'd5;
        tick();
        chk_all("t4_5a", 0, 1, 0, 0, 2, 2);
        tick();
        chk_all("t4_5b", 0, 0, 0, 0, 2, 2);
        tick();
        chk_all("t4_5c", 0, 0, 0, 0, 2, 2);
        count_in = 4'd6;
        tick();
        chk_all("t4_6", 0, 0, 0, 0, 2, 2);
        count_in = 4'd7;
        tick();
        chk_all("t4_7", 0, 0, 0, 1, 2, 2);

        // 5. Jump tally saturation, then clr on a jump edge
        match_val = 4'd15;
        for (int i = 0; i < 260; i++) begin
            count_in = (i % 2 == 0) ? 4'd0 : 4'd8;
            tick();
            if (i == 100) begin
                chk("t5_mid_jump_cnt", int'(jump_cnt), 103);
            end
        end
        chk_all("t5_sat", 0, 0, 1, 0, 2, 255);
        clr      = 1'b1;
        count_in = 4'd0;
        tick();
        chk_all("t5_clr", 0, 0, 0, 0, 0, 0);
        clr      = 1'b0;
        count_in = 4'd1;
        tick();
        chk_all("t5_after_clr", 0, 0, 0, 0, 0, 0);

        // 6. Disable mid-count, resync via SYNC, then reset during TRACK
        count_in = 4'd10;
        tick();
        chk_all("t6_jump10", 0, 0, 1, 0, 0, 1);
        for (int v = 11; v <= 14; v++) begin
            count_in = 4'(v);
            tick();
        end
        chk_all("t6_locked14", 0, 0, 0, 1, 0, 1);
        count_in = 4'd15;
        tick();
        chk("t6_locked15", int'(locked), 1);
        match_val = 4'd0;
        en        = 1'b0;
        count_in  = 4'd0;
        tick();
        chk_all("t6_disable", 0, 0, 0, 0, 0, 1);
        count_in = 4'd5;
        tick();
        chk_all("t6_idle", 0, 0, 0, 0, 0, 1);
        en       = 1'b1;
        count_in = 4'd9;
        tick();
        chk_all("t6_reen_idle", 0, 0, 0, 0, 0, 1);
        tick();
        chk_all("t6_reen_sync", 0, 0, 0, 0, 0, 1);
        count_in = 4'd11;
        tick();
        chk_all("t6_jump11", 0, 0, 1, 0, 0, 2);
        count_in = 4'd12;
        tick();
        chk_all("t6_12", 0, 0, 0, 0, 0, 2);
        reset    = 1'b1;
        count_in = 4'd3;
        tick();
        chk_all("t6_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("t6_post_idle", 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("t6_post_sync", 0, 0, 0, 0, 0, 0);
        count_in = 4'd4;
        tick();
        chk_all("t6_post_step", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
